// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and bit-timing constants.
package uart_pkg;

  typedef logic [2:0] rxState_t;

  localparam rxState_t ST_IDLE   = 3'd0;
  localparam rxState_t ST_START  = 3'd1;
  localparam rxState_t ST_DATA   = 3'd2;
  localparam rxState_t ST_PARITY = 3'd3;
  localparam rxState_t ST_STOP   = 3'd4;

  localparam logic [3:0] TICK_MID = 4'd8;
  localparam logic [3:0] TICK_MAX = 4'd15;

  function automatic logic [2:0] lastDataBit(input logic bit8);
    return bit8 ? 3'd7 : 3'd6;
  endfunction

endpackage

// File: rtl/uart_rx_async_if.sv
// Host-side bundle of the UART receiver: line, frame format, and received-byte handshake.
interface uart_rx_async_if;

  logic       baud_clock;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       rx;
  logic       read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       fifo_write;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  modport master (
    output baud_clock, bit8, parity_en, odd_n_even, rx, read_rx_byte,
    input  rx_data, rx_ready, fifo_write, parity_err, framing_err, overflow
  );

  modport slave (
    input  baud_clock, bit8, parity_en, odd_n_even, rx, read_rx_byte,
    output rx_data, rx_ready, fifo_write, parity_err, framing_err, overflow
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Brings the asynchronous rx line into the CLK domain and majority-votes the last three baud samples.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_baudClock,
  input  logic i_rx,
  output logic o_rxSync,
  output logic o_vote
);

  logic       r_sync1;
  logic       r_sync2;
  logic [2:0] r_samples;

  // Idle-high reset values keep a line held low at reset release from looking like an old start bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_samples <= 3'b111;
    end else if (i_baudClock) begin
      r_samples <= {r_samples[1:0], r_sync2};
    end
  end

  assign o_rxSync = r_sync2;
  assign o_vote   = (r_samples[0] & r_samples[1]) |
                    (r_samples[0] & r_samples[2]) |
                    (r_samples[1] & r_samples[2]);

endmodule

// File: rtl/uart_rx_async.sv
// UART receiver: 16x oversampled frame FSM with optional parity, delivering bytes to a
// holding register (RX_FIFO=0) or as a one-cycle FIFO push strobe (RX_FIFO=1).
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int RX_FIFO = 0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  uart_rx_async_if.slave  bus
);

  localparam logic HOLD_MODE = (RX_FIFO == 0);

  logic       w_rxSync;
  logic       w_vote;
  logic       w_midBit;
  logic       w_store;
  logic [7:0] w_dataByte;

  rxState_t   r_state;
  logic [3:0] r_tick;
  logic [2:0] r_bitCnt;
  logic [7:0] r_shift;
  logic       r_parityMis;
  logic [7:0] r_rxData;
  logic       r_rxReady;
  logic       r_fifoWrite;
  logic       r_parityErr;
  logic       r_framingErr;
  logic       r_overflow;

  uart_rx_sampler u_sampler (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .i_baudClock (bus.baud_clock),
    .i_rx        (bus.rx),
    .o_rxSync    (w_rxSync),
    .o_vote      (w_vote)
  );

  assign w_midBit   = bus.baud_clock && (r_tick == TICK_MID);
  assign w_store    = w_midBit && (r_state == ST_STOP);
  assign w_dataByte = bus.bit8 ? r_shift : {1'b0, r_shift[6:0]};

  // Tick stays parked at 0 while idle so a new frame always starts counting from its start edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tick <= 4'd0;
    end else if (bus.baud_clock) begin
      if (r_state == ST_IDLE || r_tick == TICK_MAX) begin
        r_tick <= 4'd0;
      end else begin
        r_tick <= r_tick + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.baud_clock && !w_rxSync) r_state <= ST_START;
        ST_START:  if (w_midBit) r_state <= w_vote ? ST_IDLE : ST_DATA;
        ST_DATA:   if (w_midBit && r_bitCnt == lastDataBit(bus.bit8))
                     r_state <= bus.parity_en ? ST_PARITY : ST_STOP;
        ST_PARITY: if (w_midBit) r_state <= ST_STOP;
        ST_STOP:   if (w_midBit) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bitCnt    <= 3'd0;
      r_shift     <= 8'd0;
      r_parityMis <= 1'b0;
    end else if (w_midBit) begin
      case (r_state)
        ST_START: begin
          r_bitCnt    <= 3'd0;
          r_shift     <= 8'd0;
          r_parityMis <= 1'b0;
        end
        ST_DATA: begin
          r_shift[r_bitCnt] <= w_vote;
          r_bitCnt          <= r_bitCnt + 3'd1;
        end
        ST_PARITY: r_parityMis <= ((^w_dataByte) ^ w_vote) != bus.odd_n_even;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rxData    <= 8'd0;
      r_fifoWrite <= 1'b0;
    end else begin
      r_fifoWrite <= w_store && !HOLD_MODE;
      if (w_store) r_rxData <= w_dataByte;
    end
  end

  // A store landing in the same cycle as a host read wins: old flags are dropped, new ones kept.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rxReady    <= 1'b0;
      r_parityErr  <= 1'b0;
      r_framingErr <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_store) begin
      r_rxReady    <= HOLD_MODE;
      r_parityErr  <= (r_parityErr  & ~bus.read_rx_byte) | r_parityMis;
      r_framingErr <= (r_framingErr & ~bus.read_rx_byte) | ~w_vote;
      r_overflow   <= ((r_overflow | (r_rxReady & HOLD_MODE)) & ~bus.read_rx_byte);
    end else if (bus.read_rx_byte) begin
      r_rxReady    <= 1'b0;
      r_parityErr  <= 1'b0;
      r_framingErr <= 1'b0;
      r_overflow   <= 1'b0;
    end
  end

  assign bus.rx_data     = r_rxData;
  assign bus.rx_ready    = r_rxReady;
  assign bus.fifo_write  = r_fifoWrite;
  assign bus.parity_err  = r_parityErr;
  assign bus.framing_err = r_framingErr;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_async.sv
// Scoreboard bench for uart_rx_async: one holding-register instance and one FIFO-mode instance
// receive identical serial frames; monitors pop expected bytes whenever a store appears.
module tb_uart_rx_async;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  logic prevReady0 = 1'b0;
  logic prevOvf0   = 1'b0;

  uart_rx_async_if if0 ();
  uart_rx_async_if if1 ();

  assign if1.baud_clock   = if0.baud_clock;
  assign if1.bit8         = if0.bit8;
  assign if1.parity_en    = if0.parity_en;
  assign if1.odd_n_even   = if0.odd_n_even;
  assign if1.rx           = if0.rx;
  assign if1.read_rx_byte = if0.read_rx_byte;

  uart_rx_async #(.RX_FIFO(0)) dut0 (.CLK(CLK), .RESET_N(RESET_N), .bus(if0.slave));
  uart_rx_async #(.RX_FIFO(1)) dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(if1.slave));

  always #5 CLK = ~CLK;

  initial begin
    if0.baud_clock = 1'b0;
    forever begin
      repeat (3) @(negedge CLK);
      if0.baud_clock = 1'b1;
      @(negedge CLK);
      if0.baud_clock = 1'b0;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expectStore(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    q0.push_back('{data: d, perr: pe, ferr: fe, ovf: ov});
    q1.push_back('{data: d, perr: pe, ferr: fe, ovf: 1'b0});
  endtask

  task automatic driveBit(input logic v, input logic glitch);
    if (glitch) begin
      if0.rx = v;  waitClk(28);
      if0.rx = ~v; waitClk(4);
      if0.rx = v;  waitClk(32);
    end else begin
      if0.rx = v;  waitClk(64);
    end
  endtask

  // One full frame (start, data LSB-first, optional parity, stop) followed by two idle bit times.
  task automatic applyStimulus(input logic [7:0] d, input int nData, input logic parEn,
                               input logic parBit, input logic stopBit, input int glitchBit);
    driveBit(1'b0, 1'b0);
    for (int i = 0; i < nData; i++) driveBit(d[i], i == glitchBit);
    if (parEn) driveBit(parBit, 1'b0);
    driveBit(stopBit, 1'b0);
    if0.rx = 1'b1;
    waitClk(128);
  endtask

  task automatic readByte();
    if0.read_rx_byte = 1'b1;
    waitClk(1);
    if0.read_rx_byte = 1'b0;
    waitClk(2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rx_data0"},     if0.rx_data,     0);
    checkOutput({tag, "_rx_ready0"},    if0.rx_ready,    0);
    checkOutput({tag, "_parity_err0"},  if0.parity_err,  0);
    checkOutput({tag, "_framing_err0"}, if0.framing_err, 0);
    checkOutput({tag, "_overflow0"},    if0.overflow,    0);
    checkOutput({tag, "_fifo_write0"},  if0.fifo_write,  0);
    checkOutput({tag, "_rx_data1"},     if1.rx_data,     0);
    checkOutput({tag, "_fifo_write1"},  if1.fifo_write,  0);
  endtask

  always @(negedge CLK) begin
    if ((if0.rx_ready && !prevReady0) || (if0.overflow && !prevOvf0)) begin
      if (q0.size() == 0) begin
        checkOutput("store0_expected", 0, 1);
      end else begin
        e0 = q0.pop_front();
        checkOutput("sb0_rx_data",     if0.rx_data,     e0.data);
        checkOutput("sb0_parity_err",  if0.parity_err,  e0.perr);
        checkOutput("sb0_framing_err", if0.framing_err, e0.ferr);
        checkOutput("sb0_overflow",    if0.overflow,    e0.ovf);
      end
    end
    prevReady0 = if0.rx_ready;
    prevOvf0   = if0.overflow;
  end

  always @(negedge CLK) begin
    if (if1.fifo_write) begin
      if (q1.size() == 0) begin
        checkOutput("store1_expected", 0, 1);
      end else begin
        e1 = q1.pop_front();
        checkOutput("sb1_rx_data",     if1.rx_data,     e1.data);
        checkOutput("sb1_parity_err",  if1.parity_err,  e1.perr);
        checkOutput("sb1_framing_err", if1.framing_err, e1.ferr);
        checkOutput("sb1_overflow",    if1.overflow,    e1.ovf);
        checkOutput("sb1_rx_ready",    if1.rx_ready,    0);
      end
    end
  end

  initial begin
    RESET_N          = 1'b0;
    if0.rx           = 1'b1;
    if0.bit8         = 1'b1;
    if0.parity_en    = 1'b0;
    if0.odd_n_even   = 1'b0;
    if0.read_rx_byte = 1'b0;
    waitClk(8);
    checkAllZero("reset");
    RESET_N = 1'b1;
    waitClk(64);

    $display("[TB] 8N1 0x55");
    expectStore(8'h55, 0, 0, 0);
    applyStimulus(8'h55, 8, 0, 0, 1, -1);
    checkOutput("ready_before_read", if0.rx_ready, 1);
    readByte();
    checkOutput("ready_after_read", if0.rx_ready, 0);

    $display("[TB] 8E1 0xA3 good and bad parity");
    if0.parity_en = 1'b1;
    expectStore(8'hA3, 0, 0, 0);
    applyStimulus(8'hA3, 8, 1, 0, 1, -1);
    readByte();
    expectStore(8'hA3, 1, 0, 0);
    applyStimulus(8'hA3, 8, 1, 1, 1, -1);
    readByte();
    checkOutput("parity_err_after_read", if0.parity_err, 0);
    if0.parity_en = 1'b0;

    $display("[TB] 7N1 framing error then recovery");
    if0.bit8 = 1'b0;
    expectStore(8'h7F, 0, 1, 0);
    applyStimulus(8'h7F, 7, 0, 0, 0, -1);
    checkOutput("framing_err_held", if0.framing_err, 1);
    readByte();
    checkOutput("framing_err_after_read", if0.framing_err, 0);
    expectStore(8'h12, 0, 0, 0);
    applyStimulus(8'h12, 7, 0, 0, 1, -1);
    readByte();
    if0.bit8 = 1'b1;

    $display("[TB] overflow without read");
    expectStore(8'h01, 0, 0, 0);
    applyStimulus(8'h01, 8, 0, 0, 1, -1);
    expectStore(8'h02, 0, 0, 1);
    applyStimulus(8'h02, 8, 0, 0, 1, -1);
    checkOutput("overflow0_held", if0.overflow, 1);
    checkOutput("overflow1_fifo", if1.overflow, 0);
    readByte();
    checkOutput("overflow_after_read", if0.overflow, 0);

    $display("[TB] short start pulse rejected");
    if0.rx = 1'b0;
    waitClk(20);
    if0.rx = 1'b1;
    waitClk(256);
    checkOutput("glitch_no_ready", if0.rx_ready, 0);

    $display("[TB] single-tick glitch inside data bit");
    expectStore(8'h0F, 0, 0, 0);
    applyStimulus(8'h0F, 8, 0, 0, 1, 5);
    readByte();

    $display("[TB] reset during data of 0x3C");
    driveBit(1'b0, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    RESET_N = 1'b0;
    if0.rx  = 1'b1;
    waitClk(5);
    checkAllZero("midreset");
    RESET_N = 1'b1;
    waitClk(64);
    expectStore(8'hC3, 0, 0, 0);
    applyStimulus(8'hC3, 8, 0, 0, 1, -1);
    readByte();

    waitClk(64);
    checkOutput("queue0_drained", q0.size(), 0);
    checkOutput("queue1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
